// File: rtl/rf_port_arbiter_if.sv
// Request and register-file port bundle for rf_port_arbiter.
// master = arbiter side, slave = requesters plus register file.
interface rf_port_arbiter_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_SIZE  = 4
);
  logic                  REQ0_WrEn, REQ0_RdEn, REQ0_Ready, REQ0_RdData_valid;
  logic [ADDR_SIZE-1:0]  REQ0_Address;
  logic [DATA_WIDTH-1:0] REQ0_WrData, REQ0_RdData;
  logic                  REQ1_WrEn, REQ1_RdEn, REQ1_Ready, REQ1_RdData_valid;
  logic [ADDR_SIZE-1:0]  REQ1_Address;
  logic [DATA_WIDTH-1:0] REQ1_WrData, REQ1_RdData;
  logic                  RF_WrEn, RF_RdEn, RF_RdData_valid;
  logic [ADDR_SIZE-1:0]  RF_Address;
  logic [DATA_WIDTH-1:0] RF_WrData, RF_RdData;

  modport master (
    input  REQ0_WrEn, REQ0_RdEn, REQ0_Address, REQ0_WrData,
    input  REQ1_WrEn, REQ1_RdEn, REQ1_Address, REQ1_WrData,
    output REQ0_Ready, REQ0_RdData, REQ0_RdData_valid,
    output REQ1_Ready, REQ1_RdData, REQ1_RdData_valid,
    output RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
    input  RF_RdData, RF_RdData_valid
  );

  modport slave (
    output REQ0_WrEn, REQ0_RdEn, REQ0_Address, REQ0_WrData,
    output REQ1_WrEn, REQ1_RdEn, REQ1_Address, REQ1_WrData,
    input  REQ0_Ready, REQ0_RdData, REQ0_RdData_valid,
    input  REQ1_Ready, REQ1_RdData, REQ1_RdData_valid,
    input  RF_WrEn, RF_RdEn, RF_Address, RF_WrData,
    output RF_RdData, RF_RdData_valid
  );
endinterface

// File: rtl/rf_port_arbiter.sv
// Two-requester arbiter for the single register-file port, one command in flight.
// Define ARB_FIXED_PRIO_EN for fixed priority (REQ0 wins ties) instead of round-robin.
module rf_port_arbiter_lane #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  grant,
  input  logic                  ret,
  input  logic [DATA_WIDTH-1:0] ret_data,
  output logic                  ready,
  output logic                  rd_vld,
  output logic [DATA_WIDTH-1:0] rd_data
);
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      ready   <= 1'b0;
      rd_vld  <= 1'b0;
      rd_data <= '0;
    end else begin
      ready  <= grant;
      rd_vld <= ret;
      if (ret) rd_data <= ret_data;
    end
endmodule

module rf_port_arbiter #(
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_SIZE      = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              CLK,
  input  logic              RST,
  rf_port_arbiter_if.master bus,
  output logic              ARB_BUSY,
  output logic              RD_TIMEOUT
);
  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  state_t state, state_nxt;

  logic [NUM_REQ-1:0]                 wr, rd, pend, grant, ret, ready, rd_vld;
  logic [NUM_REQ-1:0][ADDR_SIZE-1:0]  addr;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata, rd_data;
  logic [DATA_WIDTH-1:0]              ret_data;
  logic                               win, owner, to_hit;
  logic [7:0]                         cnt;

  assign wr    = {bus.REQ1_WrEn, bus.REQ0_WrEn};
  assign rd    = {bus.REQ1_RdEn, bus.REQ0_RdEn};
  assign addr  = {bus.REQ1_Address, bus.REQ0_Address};
  assign wdata = {bus.REQ1_WrData, bus.REQ0_WrData};
  assign pend  = wr | rd;

`ifdef ARB_FIXED_PRIO_EN
  assign win = ~pend[0];
`else
  // last = requester granted most recently; reset to 1 so REQ0 wins the first tie
  logic last;
  assign win = (&pend) ? ~last : pend[1];
  always_ff @(posedge CLK or negedge RST)
    if (!RST)                          last <= 1'b1;
    else if (state == IDLE && |pend)   last <= win;
`endif

  always_ff @(posedge CLK or negedge RST)
    if (!RST) state <= IDLE;
    else      state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (|pend) state_nxt = ISSUE;
      ISSUE:   state_nxt = bus.RF_WrEn ? IDLE : WAIT_RD;
      WAIT_RD: if (bus.RF_RdData_valid || to_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant    = '0;
    ret      = '0;
    to_hit   = (state == WAIT_RD) && !bus.RF_RdData_valid &&
               (cnt == 8'(TIMEOUT_CYCLES - 1));
    ret_data = bus.RF_RdData_valid ? bus.RF_RdData : '0;
    if (state == IDLE && |pend) grant[win] = 1'b1;
    if (state == WAIT_RD && (bus.RF_RdData_valid || to_hit)) ret[owner] = 1'b1;
  end

  // Enables are single-cycle; address/data hold after ISSUE
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      bus.RF_WrEn    <= 1'b0;
      bus.RF_RdEn    <= 1'b0;
      bus.RF_Address <= '0;
      bus.RF_WrData  <= '0;
      owner          <= 1'b0;
      cnt            <= '0;
      RD_TIMEOUT     <= 1'b0;
    end else begin
      RD_TIMEOUT <= to_hit;
      cnt        <= (state == WAIT_RD && state_nxt == WAIT_RD) ? cnt + 8'd1 : '0;
      if (|grant) begin
        bus.RF_WrEn    <= wr[win];
        bus.RF_RdEn    <= rd[win] & ~wr[win];
        bus.RF_Address <= addr[win];
        bus.RF_WrData  <= wdata[win];
        owner          <= win;
      end else begin
        bus.RF_WrEn <= 1'b0;
        bus.RF_RdEn <= 1'b0;
      end
    end

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    rf_port_arbiter_lane #(.DATA_WIDTH(DATA_WIDTH)) u_lane (
      .CLK      (CLK),
      .RST      (RST),
      .grant    (grant[i]),
      .ret      (ret[i]),
      .ret_data (ret_data),
      .ready    (ready[i]),
      .rd_vld   (rd_vld[i]),
      .rd_data  (rd_data[i])
    );
  end

  assign bus.REQ0_Ready        = ready[0];
  assign bus.REQ1_Ready        = ready[1];
  assign bus.REQ0_RdData_valid = rd_vld[0];
  assign bus.REQ1_RdData_valid = rd_vld[1];
  assign bus.REQ0_RdData       = rd_data[0];
  assign bus.REQ1_RdData       = rd_data[1];
  assign ARB_BUSY              = (state != IDLE);
endmodule

// File: tb/tb_rf_port_arbiter.sv
// Scoreboard bench for rf_port_arbiter: grant and read-return expectations are queued
// when stimulus is driven and checked when the arbiter produces Ready / RdData_valid.
`timescale 1ns/1ps
module tb_rf_port_arbiter;
  localparam int DW = 8, AW = 4, TO = 15;

  logic CLK = 1'b0, RST = 1'b0;
  logic ARB_BUSY, RD_TIMEOUT;

  rf_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus ();

  rf_port_arbiter #(.DATA_WIDTH(DW), .ADDR_SIZE(AW), .TIMEOUT_CYCLES(TO)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .bus        (bus),
    .ARB_BUSY   (ARB_BUSY),
    .RD_TIMEOUT (RD_TIMEOUT)
  );

  always #5 CLK = ~CLK;

  typedef struct { int owner; bit wr; logic [AW-1:0] addr; logic [DW-1:0] data; } gexp_t;
  typedef struct { int owner; logic [DW-1:0] data; bit to; int lat; } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int checks = 0, errors = 0;
  int cyc = 0, rdy_cyc = 0;
  int rf_lat = -1, late_req = 0;
  logic [DW-1:0] rf_val = '0;
  gexp_t ge;
  rexp_t re;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.RF_WrEn, bus.RF_RdEn, bus.RF_Address, bus.RF_WrData,
                bus.REQ0_Ready, bus.REQ1_Ready, bus.REQ0_RdData, bus.REQ1_RdData,
                bus.REQ0_RdData_valid, bus.REQ1_RdData_valid, ARB_BUSY, RD_TIMEOUT});
  endfunction

  task automatic req_set(input int id, input bit wr, input bit rd,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      bus.REQ0_WrEn = wr; bus.REQ0_RdEn = rd; bus.REQ0_Address = a; bus.REQ0_WrData = d;
    end else begin
      bus.REQ1_WrEn = wr; bus.REQ1_RdEn = rd; bus.REQ1_Address = a; bus.REQ1_WrData = d;
    end
  endtask

  // Present a command and hold it until Ready is seen (bounded wait)
  task automatic issue(input int id, input bit wr, input bit rd, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input int exp_wait);
    int n = 0;
    bit got = 1'b0;
    req_set(id, wr, rd, a, d);
    while (!got && n < 50) begin
      @(posedge CLK); #1;
      n++;
      got = (id == 0) ? bus.REQ0_Ready : bus.REQ1_Ready;
    end
    chk("ready_seen", 64'(got), 64'(1));
    if (exp_wait >= 0) chk("ready_latency", 64'(n), 64'(exp_wait));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  always @(posedge CLK) cyc++;

  // Monitor / scoreboard pop
  always @(negedge CLK) if (RST) begin
    if (bus.REQ0_Ready || bus.REQ1_Ready) begin
      chk("ready_onehot", 64'(bus.REQ0_Ready & bus.REQ1_Ready), 64'(0));
      chk("busy_in_issue", 64'(ARB_BUSY), 64'(1));
      if (gq.size() == 0) chk("grant_unexpected", 64'(bus.REQ0_Ready | bus.REQ1_Ready), 64'(0));
      else begin
        ge = gq.pop_front();
        chk("grant_owner", 64'(bus.REQ1_Ready), 64'(ge.owner));
        chk("rf_wren", 64'(bus.RF_WrEn), 64'(ge.wr));
        chk("rf_rden", 64'(bus.RF_RdEn), 64'(!ge.wr));
        chk("rf_addr", 64'(bus.RF_Address), 64'(ge.addr));
        if (ge.wr) chk("rf_wdata", 64'(bus.RF_WrData), 64'(ge.data));
      end
      rdy_cyc = cyc;
    end
    if (bus.REQ0_RdData_valid || bus.REQ1_RdData_valid) begin
      chk("rdvalid_onehot", 64'(bus.REQ0_RdData_valid & bus.REQ1_RdData_valid), 64'(0));
      chk("busy_at_return", 64'(ARB_BUSY), 64'(0));
      if (rq.size() == 0)
        chk("return_unexpected", 64'(bus.REQ0_RdData_valid | bus.REQ1_RdData_valid), 64'(0));
      else begin
        re = rq.pop_front();
        chk("return_owner", 64'(bus.REQ1_RdData_valid), 64'(re.owner));
        chk("return_data", 64'(re.owner != 0 ? bus.REQ1_RdData : bus.REQ0_RdData), 64'(re.data));
        chk("return_timeout", 64'(RD_TIMEOUT), 64'(re.to));
        chk("return_latency", 64'(cyc - rdy_cyc), 64'(re.lat));
      end
    end else chk("timeout_alone", 64'(RD_TIMEOUT), 64'(0));
  end

  // Register-file read responder
  initial begin
    int late_done = 0;
    bus.RF_RdData = '0;
    bus.RF_RdData_valid = 1'b0;
    forever begin
      @(posedge CLK); #1;
      if (late_req != late_done) begin
        late_done = late_req;
        bus.RF_RdData = 8'hFF; bus.RF_RdData_valid = 1'b1;
        @(posedge CLK); #1;
        bus.RF_RdData = '0; bus.RF_RdData_valid = 1'b0;
      end else if (bus.RF_RdEn && rf_lat >= 0) begin
        repeat (rf_lat) begin @(posedge CLK); #1; end
        bus.RF_RdData = rf_val; bus.RF_RdData_valid = 1'b1;
        @(posedge CLK); #1;
        bus.RF_RdData = '0; bus.RF_RdData_valid = 1'b0;
      end
    end
  end

  initial begin
    int ord [4];
    int k0 = 0, k1 = 0;
    logic [AW-1:0] a0 [2], a1 [2];
    logic [DW-1:0] d0 [2], d1 [2];
    a0[0] = 4'h1; a0[1] = 4'h2; d0[0] = 8'h11; d0[1] = 8'h22;
    a1[0] = 4'h8; a1[1] = 4'h9; d1[0] = 8'h81; d1[1] = 8'h92;
    req_set(0, 0, 0, '0, '0);
    req_set(1, 0, 0, '0, '0);

    RST = 1'b0;
    idle(3);
    chk("reset_outputs", outs(), 64'(0));
    RST = 1'b1;
    idle(2);
    chk("idle_outputs", outs(), 64'(0));

    // Both requesters stream writes from reset
`ifdef ARB_FIXED_PRIO_EN
    ord[0] = 0; ord[1] = 0; ord[2] = 1; ord[3] = 1;
`else
    ord[0] = 0; ord[1] = 1; ord[2] = 0; ord[3] = 1;
`endif
    for (int i = 0; i < 4; i++) begin
      if (ord[i] == 0) begin gq.push_back('{0, 1'b1, a0[k0], d0[k0]}); k0++; end
      else             begin gq.push_back('{1, 1'b1, a1[k1], d1[k1]}); k1++; end
    end
    fork
      begin
        issue(0, 1, 0, a0[0], d0[0], -1);
        issue(0, 1, 0, a0[1], d0[1], -1);
        req_set(0, 0, 0, '0, '0);
      end
      begin
        issue(1, 1, 0, a1[0], d1[0], -1);
        issue(1, 1, 0, a1[1], d1[1], -1);
        req_set(1, 0, 0, '0, '0);
      end
    join
    idle(3);

    // Single write, then write+read together (write wins)
    gq.push_back('{0, 1'b1, 4'h3, 8'hA5});
    issue(0, 1, 0, 4'h3, 8'hA5, 1);
    req_set(0, 0, 0, '0, '0);
    idle(3);
    gq.push_back('{1, 1'b1, 4'h7, 8'h5A});
    issue(1, 1, 1, 4'h7, 8'h5A, 1);
    req_set(1, 0, 0, '0, '0);
    idle(3);

    // Reads with RF responses
    rf_lat = 1; rf_val = 8'h3C;
    gq.push_back('{1, 1'b0, 4'h5, 8'h00});
    rq.push_back('{1, 8'h3C, 1'b0, 2});
    issue(1, 0, 1, 4'h5, '0, 1);
    req_set(1, 0, 0, '0, '0);
    idle(6);
    rf_lat = 3; rf_val = 8'h96;
    gq.push_back('{0, 1'b0, 4'hA, 8'h00});
    rq.push_back('{0, 8'h96, 1'b0, 4});
    issue(0, 0, 1, 4'hA, '0, 1);
    req_set(0, 0, 0, '0, '0);
    idle(8);

    // Read timeout: no RF response
    rf_lat = -1;
    gq.push_back('{0, 1'b0, 4'hC, 8'h00});
    rq.push_back('{0, 8'h00, 1'b1, TO + 1});
    issue(0, 0, 1, 4'hC, '0, 1);
    req_set(0, 0, 0, '0, '0);
    idle(TO + 5);
    chk("idle_after_timeout", 64'(ARB_BUSY), 64'(0));

    // Reset during WAIT_RD, then a late RF valid must be ignored
    gq.push_back('{1, 1'b0, 4'h2, 8'h00});
    issue(1, 0, 1, 4'h2, '0, 1);
    req_set(1, 0, 0, '0, '0);
    idle(4);
    chk("busy_in_wait_rd", 64'(ARB_BUSY), 64'(1));
    RST = 1'b0;
    #1;
    chk("reset_mid_outputs", outs(), 64'(0));
    idle(1);
    RST = 1'b1;
    late_req++;
    idle(5);
    chk("idle_after_reset", 64'(ARB_BUSY), 64'(0));

    // Arbiter still serves after the abandoned read
    gq.push_back('{0, 1'b1, 4'hF, 8'hC3});
    issue(0, 1, 0, 4'hF, 8'hC3, 1);
    req_set(0, 0, 0, '0, '0);
    idle(3);

    chk("grant_queue_drained", 64'(gq.size()), 64'(0));
    chk("return_queue_drained", 64'(rq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the single register-file access port between two requesters: REQ0 (system controller) and REQ1 (configuration/debug agent).
- Round-robin arbitration with one command in flight at a time.
- Reads stay owned until RF_RdData_valid returns or a timeout fires; read data and valid are routed only to the owning requester.
- Sits between the requesters and the register file, in the register-file clock domain.

Parameters:
- DATA_WIDTH, 8, register-file data width.
- ADDR_SIZE, 4, register-file address width.
- TIMEOUT_CYCLES, 15, maximum WAIT_RD cycles before the read is aborted. Range 1..255.

Ports:
- CLK  input  1  clock.
- RST  input  1  asynchronous active-low reset.
- REQ0_WrEn  input  1  REQ0 write request (level; held until REQ0_Ready).
- REQ0_RdEn  input  1  REQ0 read request (level; held until REQ0_Ready).
- REQ0_Address  input  ADDR_SIZE  REQ0 address.
- REQ0_WrData  input  DATA_WIDTH  REQ0 write data.
- REQ0_Ready  output  1  one-cycle command-accepted pulse to REQ0.
- REQ0_RdData  output  DATA_WIDTH  read data returned to REQ0.
- REQ0_RdData_valid  output  1  one-cycle read-return pulse to REQ0.
- REQ1_WrEn, REQ1_RdEn, REQ1_Address, REQ1_WrData, REQ1_Ready, REQ1_RdData, REQ1_RdData_valid: same as REQ0, for REQ1.
- RF_WrEn  output  1  register-file write enable.
- RF_RdEn  output  1  register-file read enable.
- RF_Address  output  ADDR_SIZE  register-file address.
- RF_WrData  output  DATA_WIDTH  register-file write data.
- RF_RdData  input  DATA_WIDTH  register-file read data.
- RF_RdData_valid  input  1  register-file read-data valid.
- ARB_BUSY  output  1  high whenever state is not IDLE.
- RD_TIMEOUT  output  1  one-cycle pulse when a read aborts.

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer favours REQ0, timeout counter 0.
- A requester is pending when WrEn or RdEn is high. If both are high, the command is a write and the read is ignored.
- FSM states: IDLE, ISSUE, WAIT_RD.
- IDLE:
  - If any requester is pending, grant one and move to ISSUE at the next edge.
  - On that edge, register the winner's Address/WrData/WrEn/RdEn into the RF_* outputs and record the owner.
  - Both pending: grant the requester NOT granted last. Only one pending: grant it regardless of the pointer.
  - The pointer updates to the winner on each grant.
- ISSUE (exactly 1 cycle):
  - RF_WrEn or RF_RdEn is high.
  - The owner's REQx_Ready is high; the other Ready stays 0.
  - Next state is IDLE for a write, WAIT_RD for a read. RF_* enables clear at that edge; address and data may hold.
- WAIT_RD:
  - The timeout counter increments each cycle.
  - When RF_RdData_valid=1: drive owner REQx_RdData=RF_RdData and REQx_RdData_valid=1 for one cycle (registered, next cycle), then go to IDLE.
  - When the counter reaches TIMEOUT_CYCLES with no valid: pulse RD_TIMEOUT and owner REQx_RdData_valid=1 with REQx_RdData=0 for one cycle, then go to IDLE.
  - The counter clears on leaving WAIT_RD.
- Non-owner RdData_valid is never asserted. RF_RdData_valid outside WAIT_RD is ignored.
- Latency:
  - Write: request seen in cycle N, RF_WrEn high in N+1, Ready in N+1.
  - Read: RF_RdEn and Ready in N+1; RdData_valid to owner one cycle after RF_RdData_valid.
- Requesters drop their request the cycle after sampling Ready. A request still held in the IDLE cycle after ISSUE is treated as a new command.
- Requests that arrive during ISSUE or WAIT_RD wait; they are not lost while held.
- Reset mid-operation: immediate return to IDLE with all outputs 0. An in-flight read is abandoned, and no valid or timeout is issued.
- Back-to-back writes from both requesters, both continuously pending: grants alternate 0,1,0,1; each grant takes 2 cycles (IDLE+ISSUE).

Optional Feature:
- Macro: ARB_FIXED_PRIO_EN.
- Defined: fixed priority; REQ0 always wins when both are pending, and the round-robin pointer is removed.
- Undefined: round-robin as described above.

Test Plan:
- Reset release, no requests -> all outputs 0, ARB_BUSY=0.
- REQ0 write addr 0x3 data 0xA5 -> next cycle RF_WrEn=1, RF_Address=0x3, RF_WrData=0xA5, REQ0_Ready=1, REQ1_Ready=0.
- REQ0 and REQ1 both write continuously after reset -> grant order REQ0, REQ1, REQ0, REQ1. With ARB_FIXED_PRIO_EN defined: REQ0 on every grant.
- REQ1 read addr 0x5; RF returns 0x3C with valid 1 cycle after RF_RdEn -> REQ1_RdData=0x3C, REQ1_RdData_valid pulse, REQ0_RdData_valid stays 0.
- REQ0 read, RF_RdData_valid never asserted -> after 15 WAIT_RD cycles: RD_TIMEOUT pulse, REQ0_RdData_valid=1 with data 0x00, state IDLE.
- RST low during WAIT_RD, then released; late RF_RdData_valid arrives -> no RdData_valid to either requester, state IDLE.
